// File: rtl/cpu16_pkg.sv
// Shared constants, state encoding and digit helper for the cpu16 BCD input path.
package cpu16_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned ITER       = DATA_WIDTH + 1;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W      = 5;

  localparam logic [ITER-1:0] MAX_POS     = ITER'(32767);
  localparam logic [ITER-1:0] MAX_NEG_MAG = ITER'(32768);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One reverse double-dabble correction cell: digits at or above 8 lose 3 after the right shift.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin16_seq.sv
// Sequential sign + 5-digit BCD to 16-bit two's-complement converter, one shift per clock.
// Optional macro SATURATE_EN: out-of-range magnitudes clamp to 16'h7FFF / 16'h8000 instead of zero.
module bcd_to_bin16_seq
  import cpu16_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  negative,
  input  logic [3:0]            bcd_digit0,
  input  logic [3:0]            bcd_digit1,
  input  logic [3:0]            bcd_digit2,
  input  logic [3:0]            bcd_digit3,
  input  logic [3:0]            bcd_digit4,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err_range,
  output logic                  err_digit
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_W-1:0]     bcd_q;
  logic [ITER-1:0]      acc_q;
  logic                 neg_q;
  logic                 pend_q;

  logic [BCD_W-1:0]      in_bcd;
  logic                  in_digit_err;
  logic [BCD_W+ITER-1:0] shifted;
  logic [BCD_W-1:0]      bcd_sh;
  logic [BCD_W-1:0]      bcd_adj;
  logic [ITER-1:0]       acc_sh;
  logic                  range_bad;
  logic [DATA_WIDTH-1:0] signed_val;
  logic [DATA_WIDTH-1:0] range_val;

  assign in_bcd       = {bcd_digit4, bcd_digit3, bcd_digit2, bcd_digit1, bcd_digit0};
  assign in_digit_err = digit_bad(bcd_digit0) | digit_bad(bcd_digit1) | digit_bad(bcd_digit2)
                      | digit_bad(bcd_digit3) | digit_bad(bcd_digit4);

  // BCD LSB migrates into the binary accumulator MSB on every shift.
  assign shifted = {bcd_q, acc_q} >> 1;
  assign bcd_sh  = shifted[BCD_W+ITER-1:ITER];
  assign acc_sh  = shifted[ITER-1:0];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_sh[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign range_bad  = !pend_q && (neg_q ? (acc_q > MAX_NEG_MAG) : (acc_q > MAX_POS));
  assign signed_val = neg_q ? DATA_WIDTH'(ITER'(0) - acc_q) : DATA_WIDTH'(acc_q);

`ifdef SATURATE_EN
  assign range_val = neg_q ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  assign range_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bcd_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      pend_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      err_range <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bcd_q  <= in_bcd;
            acc_q  <= '0;
            neg_q  <= negative;
            pend_q <= in_digit_err;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_adj;
          acc_q <= acc_sh;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          err_digit <= pend_q;
          err_range <= range_bad;
          if (pend_q) begin
            result <= '0;
          end else if (range_bad) begin
            result <= range_val;
          end else begin
            result <= signed_val;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin16_seq.sv
// Directed bench for bcd_to_bin16_seq; expectations follow SATURATE_EN when defined.
module tb_bcd_to_bin16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        negative;
  logic [3:0]  d0, d1, d2, d3, d4;
  logic        busy, done, err_range, err_digit;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_cnt;
  int done_cnt;

  bcd_to_bin16_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .negative   (negative),
    .bcd_digit0 (d0),
    .bcd_digit1 (d1),
    .bcd_digit2 (d2),
    .bcd_digit3 (d3),
    .bcd_digit4 (d4),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .err_range  (err_range),
    .err_digit  (err_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic neg, input logic [3:0] a4, input logic [3:0] a3,
                        input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
    negative = neg;
    d4 = a4; d3 = a3; d2 = a2; d1 = a1; d0 = a0;
  endtask

  // Accept one start, then count cycles until done (bounded); lat=18 expected.
  task automatic convert(input logic neg, input logic [3:0] a4, input logic [3:0] a3,
                         input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
    @(negedge clk);
    set_in(neg, a4, a3, a2, a1, a0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 || lat >= 40) break;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'h0);

    convert(1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3);
    chk("p123_latency", 32'(lat), 32'd18);
    chk("p123_busy_cycles", 32'(busy_cnt), 32'd17);
    chk("p123_result", 32'(result), 32'h007B);
    chk("p123_errs", 32'({err_range, err_digit}), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse_one_cycle", 32'(done), 32'd0);
    chk("result_held", 32'(result), 32'h007B);

    convert(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd8);
    chk("n32768_result", 32'(result), 32'h8000);
    chk("n32768_err_range", 32'(err_range), 32'd0);

    convert(1'b0, 4'd3, 4'd2, 4'd7, 4'd6, 4'd7);
    chk("p32767_result", 32'(result), 32'h7FFF);

    convert(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1);
    chk("n1_result", 32'(result), 32'hFFFF);

    convert(1'b0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("p40000_err_range", 32'(err_range), 32'd1);
    chk("p40000_err_digit", 32'(err_digit), 32'd0);
`ifdef SATURATE_EN
    chk("p40000_result", 32'(result), 32'h7FFF);
`else
    chk("p40000_result", 32'(result), 32'h0000);
`endif

    convert(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd9);
    chk("n32769_err_range", 32'(err_range), 32'd1);
`ifdef SATURATE_EN
    chk("n32769_result", 32'(result), 32'h8000);
`else
    chk("n32769_result", 32'(result), 32'h0000);
`endif

    convert(1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    chk("p99999_err_range", 32'(err_range), 32'd1);

    convert(1'b0, 4'd0, 4'd0, 4'hA, 4'd0, 4'd0);
    chk("bad_digit_latency", 32'(lat), 32'd18);
    chk("bad_digit_err_digit", 32'(err_digit), 32'd1);
    chk("bad_digit_err_range", 32'(err_range), 32'd0);
    chk("bad_digit_result", 32'(result), 32'h0);

    convert(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("neg_zero_result", 32'(result), 32'h0);
    chk("neg_zero_errs", 32'({err_range, err_digit}), 32'd0);

    // Second start during conversion must be ignored.
    @(negedge clk);
    set_in(1'b0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    chk("ignored_start_done_count", 32'(done_cnt), 32'd1);
    chk("ignored_start_result", 32'(result), 32'h01F4);

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    set_in(1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_result", 32'(result), 32'h0);
    chk("midreset_errs", 32'({done, err_range, err_digit}), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    chk("midreset_no_done", 32'(done_cnt), 32'd0);

    convert(1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    chk("after_reset_latency", 32'(lat), 32'd18);
    chk("after_reset_result", 32'(result), 32'h04D2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin16_seq.md
Name: bcd_to_bin16_seq

Overview:
Sequential BCD-to-binary converter: the input-side inverse of the binary-to-BCD display path. Takes a sign flag plus five BCD digits (from switch/keypad entry on the FPGA board) and produces a 16-bit two's-complement operand for cpu_16bit. Uses the reverse double-dabble algorithm (shift right, subtract 3 from any digit >= 8), one iteration per clock. Uses a start/busy/done handshake.

Parameters:
DATA_WIDTH, 16, width of the binary result (two's complement).
BCD_DIGITS, 5, number of BCD input digits (digit0 = ones).
ITER, DATA_WIDTH+1, shift iterations; 17 covers a magnitude up to 99999 before the range check.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
negative  input  1  sign of the entered value (1 = negative)
bcd_digit0..bcd_digit4  input  4 each  BCD digits, digit0 = ones, digit4 = ten-thousands
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result/err valid from this cycle
result  output  16  signed binary result, held until the next accepted start
err_range  output  1  magnitude outside [-32768, 32767]
err_digit  output  1  any input digit > 9

Behaviour:
- Reset (synchronous, active-high, dominates start): state=IDLE, busy=0, done=0, result=16'h0000, err_range=0, err_digit=0, iteration counter=0.
- Reset mid-conversion: aborts the conversion and returns to the reset values; no done pulse.
- States: IDLE -> CONV -> FINISH -> IDLE.
- IDLE: on start=1, capture the 20-bit BCD vector and the sign, clear the 17-bit shift accumulator, counter=0, compute err_digit_pending (any digit > 9), then go to CONV. done=0 in every cycle except the FINISH-exit cycle.
- CONV, each cycle:
  - shift {bcd, acc} right by 1 (bcd LSB into acc MSB);
  - each 4-bit bcd digit >= 8 is decremented by 3;
  - counter increments; after ITER (17) cycles, go to FINISH.
- FINISH, one cycle, registers the outputs:
  - mag = acc[16:0];
  - err_digit = pending flag;
  - err_range = !err_digit && ((!negative && mag > 32767) || (negative && mag > 32768));
  - if no error: result = negative ? -mag : mag, truncated to 16 bits;
  - on error: result per Optional Feature; err_digit forces result=0;
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency is fixed and independent of data or error: done is high exactly ITER+1 = 18 cycles after the cycle in which start was sampled.
- start while busy (CONV/FINISH) is ignored and not queued.
- start high in the same cycle done pulses: ignored, because the block is still in FINISH. start held high continuously re-triggers once the block is back in IDLE.
- Negative zero: negative=1 with all digits 0 gives result=0, no error.
- Inputs are sampled only at acceptance; changes during CONV have no effect.
- result, err_range and err_digit hold their values until the next FINISH or a reset.

Optional Feature:
SATURATE_EN
- Defined: on err_range, result saturates to 16'h7FFF (positive) or 16'h8000 (negative).
- Not defined: result=16'h0000 on err_range.
- err_digit always gives result 0.

Decomposition:
- Shared package cpu16_pkg: DATA_WIDTH, BCD_DIGITS, ITER, MAX_POS=32767, MAX_NEG_MAG=32768, and the state encoding (IDLE, CONV, FINISH).
- One natural sub-module, bcd_digit_adj: a combinational 4-bit "if >= 8 then -3" cell, instantiated BCD_DIGITS times inside the CONV datapath.

Test Plan:
- reset, then start with +00123 -> done exactly 18 cycles later; result=16'h007B; busy high for cycles 1..17 after start; errors 0.
- -32768 -> result=16'h8000, err_range=0; +32767 -> 16'h7FFF; -00001 -> 16'hFFFF.
- +40000 -> err_range=1; result=16'h0000 without SATURATE_EN, 16'h7FFF with it; -32769 with SATURATE_EN -> 16'h8000.
- digit2=4'hA -> err_digit=1, err_range=0, result=0, still 18-cycle latency; -00000 -> result=0, no error.
- start pulsed again at cycle 5 of a conversion with new digits -> ignored, first result unchanged, exactly one done.
- reset asserted at cycle 10 of a conversion -> all outputs at reset values next cycle, no done; a fresh start then converts normally.
